// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bus for the alu_issue stage.
// slave: stage view; master: requester/ALU/retire view.
interface alu_issue_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [2:0]       req_rd;
    logic [2:0]       req_rs;
    logic [2:0]       req_rt;
    logic             req_imm_en;
    logic [WIDTH-1:0] req_imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cont;
    logic [WIDTH-1:0] alu_result;
    logic             done_valid;
    logic [2:0]       done_rd;
    logic [WIDTH-1:0] done_data;

    modport slave (
        input  req_valid, req_op, req_rd, req_rs, req_rt,
        input  req_imm_en, req_imm, alu_result,
        output req_ready, alu_a, alu_b, alu_cont,
        output done_valid, done_rd, done_data
    );

    modport master (
        output req_valid, req_op, req_rd, req_rs, req_rt,
        output req_imm_en, req_imm, alu_result,
        input  req_ready, alu_a, alu_b, alu_cont,
        input  done_valid, done_rd, done_data
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage around a registered ALU: IDLE -> ISSUE -> WB.
// Optional DBG_RF_PORT_EN adds a combinational register-file peek port.
module alu_issue #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_if.slave       bus
`ifdef DBG_RF_PORT_EN
    ,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rf [NREG];
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_cont;
    logic [2:0]       r_rd;
    logic             r_done_valid;
    logic [2:0]       r_done_rd;
    logic [WIDTH-1:0] r_done_data;

    logic [WIDTH-1:0] w_rs_data;
    logic [WIDTH-1:0] w_rt_data;

    // r0 is never written, but the guard keeps the zero explicit
    assign w_rs_data = (bus.req_rs == 3'd0) ? '0 : r_rf[bus.req_rs];
    assign w_rt_data = (bus.req_rt == 3'd0) ? '0 : r_rf[bus.req_rt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cont   <= 3'b000;
            r_rd         <= 3'd0;
            r_done_valid <= 1'b0;
            r_done_rd    <= 3'd0;
            r_done_data  <= '0;
        end else begin
            r_done_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_alu_a    <= w_rs_data;
                        r_alu_b    <= bus.req_imm_en ? bus.req_imm : w_rt_data;
                        r_alu_cont <= bus.req_op;
                        r_rd       <= bus.req_rd;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WB;
                S_WB: begin
                    if (r_rd != 3'd0) r_rf[r_rd] <= bus.alu_result;
                    r_done_valid <= 1'b1;
                    r_done_rd    <= r_rd;
                    r_done_data  <= bus.alu_result;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_cont   = r_alu_cont;
    assign bus.done_valid = r_done_valid;
    assign bus.done_rd    = r_done_rd;
    assign bus.done_data  = r_done_data;

`ifdef DBG_RF_PORT_EN
    assign dbg_data = (dbg_addr == 3'd0) ? '0 : r_rf[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural registered ALU.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_issue;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   n_acc;

    alu_issue_if #(.WIDTH(8)) bif ();

`ifdef DBG_RF_PORT_EN
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
`endif

    alu_issue #(
        .WIDTH (8),
        .NREG  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bif.slave)
`ifdef DBG_RF_PORT_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
    logic [7:0] w_bb;
    logic [7:0] w_sum;
    assign w_bb  = bif.alu_cont[2] ? ~bif.alu_b : bif.alu_b;
    assign w_sum = bif.alu_a + w_bb + {7'd0, bif.alu_cont[2]};

    always @(posedge clk) begin
        case (bif.alu_cont[1:0])
            2'b00: bif.alu_result <= bif.alu_a & w_bb;
            2'b01: bif.alu_result <= bif.alu_a | w_bb;
            2'b10: bif.alu_result <= w_sum;
            default: bif.alu_result <= {7'd0, w_sum[7]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic imm_en,
                         input logic [7:0] imm, input logic [7:0] ea,
                         input logic [7:0] eb, input logic [7:0] ed);
        bif.req_op     = op;
        bif.req_rd     = rd;
        bif.req_rs     = rs;
        bif.req_rt     = rt;
        bif.req_imm_en = imm_en;
        bif.req_imm    = imm;
        bif.req_valid  = 1'b1;
        chk({tag, ".ready_idle"}, 32'(bif.req_ready), 32'd1);
        @(negedge clk);
        bif.req_valid = 1'b0;
        chk({tag, ".ready_issue"}, 32'(bif.req_ready), 32'd0);
        chk({tag, ".alu_a"}, 32'(bif.alu_a), 32'(ea));
        chk({tag, ".alu_b"}, 32'(bif.alu_b), 32'(eb));
        chk({tag, ".alu_cont"}, 32'(bif.alu_cont), 32'(op));
        @(negedge clk);
        chk({tag, ".ready_wb"}, 32'(bif.req_ready), 32'd0);
        chk({tag, ".done_early"}, 32'(bif.done_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".done_valid"}, 32'(bif.done_valid), 32'd1);
        chk({tag, ".done_rd"}, 32'(bif.done_rd), 32'(rd));
        chk({tag, ".done_data"}, 32'(bif.done_data), 32'(ed));
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        n_acc          = 0;
        rst_n          = 1'b0;
        bif.req_valid  = 1'b0;
        bif.req_op     = 3'd0;
        bif.req_rd     = 3'd0;
        bif.req_rs     = 3'd0;
        bif.req_rt     = 3'd0;
        bif.req_imm_en = 1'b0;
        bif.req_imm    = 8'd0;
`ifdef DBG_RF_PORT_EN
        dbg_addr       = 3'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(bif.req_ready), 32'd1);
        chk("rst.done_valid", 32'(bif.done_valid), 32'd0);
        chk("rst.alu_a", 32'(bif.alu_a), 32'd0);
        chk("rst.alu_b", 32'(bif.alu_b), 32'd0);
        chk("rst.alu_cont", 32'(bif.alu_cont), 32'd0);
        chk("rst.done_rd", 32'(bif.done_rd), 32'd0);
        chk("rst.done_data", 32'(bif.done_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD r1=r0+9, reset asserted while in WB
        bif.req_op     = 3'b010;
        bif.req_rd     = 3'd1;
        bif.req_rs     = 3'd0;
        bif.req_imm_en = 1'b1;
        bif.req_imm    = 8'h09;
        bif.req_valid  = 1'b1;
        @(negedge clk);
        bif.req_valid = 1'b0;
        chk("midrst.alu_b", 32'(bif.alu_b), 32'h09);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.done_valid", 32'(bif.done_valid), 32'd0);
        chk("midrst.alu_cont", 32'(bif.alu_cont), 32'd0);
        chk("midrst.alu_b", 32'(bif.alu_b), 32'd0);
        chk("midrst.ready", 32'(bif.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post.done_valid", 32'(bif.done_valid), 32'd0);
        chk("post.ready", 32'(bif.req_ready), 32'd1);

        // r1 must read 0 after the dropped op
        issue("rd_r1", 3'b010, 3'd6, 3'd1, 3'd0, 1'b1, 8'h00,
              8'h00, 8'h00, 8'h00);
        issue("add_r1", 3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05,
              8'h00, 8'h05, 8'h05);
        issue("sub_r2", 3'b110, 3'd2, 3'd1, 3'd0, 1'b1, 8'h07,
              8'h05, 8'h07, 8'hFE);
        issue("slt_r3", 3'b111, 3'd3, 3'd1, 3'd0, 1'b1, 8'h07,
              8'h05, 8'h07, 8'h01);
        issue("add_r4a", 3'b010, 3'd4, 3'd1, 3'd1, 1'b0, 8'hAA,
              8'h05, 8'h05, 8'h0A);
        issue("add_r4b", 3'b010, 3'd4, 3'd4, 3'd1, 1'b0, 8'hAA,
              8'h0A, 8'h05, 8'h0F);

        // Continuous request: r7 += 1 three times across 9 cycles
        bif.req_op     = 3'b010;
        bif.req_rd     = 3'd7;
        bif.req_rs     = 3'd7;
        bif.req_imm_en = 1'b1;
        bif.req_imm    = 8'h01;
        bif.req_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("hold.ready", 32'(bif.req_ready), 32'((i % 3) == 0));
            if (bif.req_ready) n_acc++;
            @(negedge clk);
        end
        bif.req_valid = 1'b0;
        chk("hold.accepts", 32'(n_acc), 32'd3);
        chk("hold.done_valid", 32'(bif.done_valid), 32'd1);
        chk("hold.done_data", 32'(bif.done_data), 32'h03);
        @(negedge clk);
        chk("pulse.done_valid", 32'(bif.done_valid), 32'd0);
        chk("pulse.done_hold", 32'(bif.done_data), 32'h03);

        issue("add_r0", 3'b010, 3'd0, 3'd0, 3'd0, 1'b1, 8'h33,
              8'h00, 8'h33, 8'h33);
        issue("add_r5", 3'b010, 3'd5, 3'd0, 3'd0, 1'b1, 8'h00,
              8'h00, 8'h00, 8'h00);
        issue("or_r6", 3'b001, 3'd6, 3'd4, 3'd0, 1'b1, 8'h30,
              8'h0F, 8'h30, 8'h3F);
        issue("and_r6", 3'b000, 3'd6, 3'd6, 3'd2, 1'b0, 8'h00,
              8'h3F, 8'hFE, 8'h3E);

`ifdef DBG_RF_PORT_EN
        dbg_addr = 3'd0;
        #1 chk("dbg.r0", 32'(dbg_data), 32'd0);
        dbg_addr = 3'd1;
        #1 chk("dbg.r1", 32'(dbg_data), 32'h05);
        dbg_addr = 3'd6;
        #1 chk("dbg.r6", 32'(dbg_data), 32'h3E);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
